// File: rtl/miner_pkg.sv
// Shared types and widths for the miner-side blocks.
package miner_pkg;
    localparam int NONCE_W = 32;
    localparam int DROP_W  = 8;

    typedef logic [NONCE_W-1:0] nonce_t;
endpackage

// File: rtl/miner_rr_arb.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping modulo N.
module miner_rr_arb #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          vld
);

    always_comb begin
        int unsigned j;
        gnt     = '0;
        gnt_idx = '0;
        vld     = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (en && !vld && req[j]) begin
                vld     = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/miner_nonce_collector.sv
// Collects per-core found pulses, arbitrates them round-robin into a FIFO,
// and exposes the FIFO head to the register read path.
module miner_nonce_collector
    import miner_pkg::*;
#(
    parameter int CORES = 2,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                     clk_extra_c0,
    input  logic                     rst_main_n,
    input  logic                     new_block,
    input  logic [CORES-1:0]         found_m,
    input  logic [CORES*NONCE_W-1:0] nonce_m,
    input  logic                     pop,
    output logic                     rd_valid,
    output nonce_t                   rd_nonce,
    output logic [AW:0]              count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;

    logic [CORES-1:0] pend, gnt, capture, drop;
    nonce_t           hold [CORES];
    nonce_t           mem  [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [PW-1:0]    rr_ptr, gnt_idx;
    logic             gnt_vld, full, push_ok, do_pop;
    logic [5:0]       n_drop;
    logic [DROP_W:0]  drop_sum;

    assign full     = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign rd_valid = wr_ptr != rd_ptr;
    assign do_pop   = pop & rd_valid;
    assign push_ok  = !full || do_pop;
    assign count    = wr_ptr - rd_ptr;
    assign rd_nonce = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

    // A core granted this cycle frees its holding slot, so a new hit is a recapture, not a drop.
    assign capture = found_m & (~pend | gnt);
    assign drop    = found_m & pend & ~gnt;

    miner_rr_arb #(.N(CORES), .IW(PW)) u_arb (
        .req     (pend),
        .ptr     (rr_ptr),
        .en      (push_ok),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .vld     (gnt_vld)
    );

    always_comb begin
        n_drop = '0;
        for (int i = 0; i < CORES; i++) begin
            n_drop = n_drop + {5'b0, drop[i]};
        end
        drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(n_drop);
    end

    always_ff @(posedge clk_extra_c0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            pend     <= '0;
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (new_block) begin
            pend     <= '0;
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            pend <= (pend & ~gnt) | capture;
            if (gnt_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (int'(gnt_idx) == CORES - 1) ? '0 : gnt_idx + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (|drop) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
            end
        end
    end

    // Data-only storage: no reset needed, validity is tracked by pend and the pointers.
    always_ff @(posedge clk_extra_c0) begin
        if (!new_block) begin
            for (int i = 0; i < CORES; i++) begin
                if (capture[i]) begin
                    hold[i] <= nonce_m[i*NONCE_W +: NONCE_W];
                end
            end
            if (gnt_vld) begin
                mem[wr_ptr[AW-1:0]] <= hold[gnt_idx];
            end
        end
    end

endmodule

// File: doc/miner_nonce_collector.md
Name: miner_nonce_collector

Overview:
- Sits directly downstream of the CORES miner cores, on the miner clock.
- Collects single-cycle found_m pulses and their nonces from every core.
- Serialises them with a round-robin arbiter into a FIFO, so simultaneous or back-to-back hits are never silently lost.
- Presents the FIFO head to the OCL register read path; the result register read pops one entry.

Parameters:
- CORES, 2, number of miner cores feeding the block (1..32).
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- AW, $clog2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
- clk_extra_c0  in  1  miner clock; the only clock in this block.
- rst_main_n  in  1  asynchronous active-low reset.
- new_block  in  1  synchronous flush pulse, asserted for one cycle when a new block header is loaded.
- found_m  in  CORES  per-core found strobe, one cycle wide.
- nonce_m  in  CORES*32  per-core nonce; slice i is nonce_m[i*32 +: 32], valid while found_m[i]=1.
- pop  in  1  consume the head entry; ignored when rd_valid=0.
- rd_valid  out  1  FIFO not empty.
- rd_nonce  out  32  head nonce; forced to 0 when rd_valid=0.
- count  out  AW+1  number of FIFO entries, 0..DEPTH.
- overflow  out  1  sticky flag: at least one nonce has been dropped.
- drop_cnt  out  8  dropped-nonce counter; saturates at 255.

Behaviour:
- Reset, asynchronous, rst_main_n=0: all pointers and pend bits cleared; rr_ptr=0; count=0; rd_valid=0; rd_nonce=0; overflow=0; drop_cnt=0. FIFO storage is not reset.
- Capture stage, per core i:
  - found_m[i]=1 and pend[i]=0: hold[i]<=nonce slice, pend[i]<=1.
  - found_m[i]=1 and pend[i]=1, and core i is not granted this cycle: the new nonce is dropped; hold[i] is unchanged; overflow<=1; drop_cnt increments (saturating).
  - found_m[i]=1 in the same cycle that core i is granted: this is not a drop; hold[i]<=new nonce, pend[i] stays 1.
- Arbitration stage:
  - Round-robin over pend. Search starts at rr_ptr; the grant goes to the first set bit at or after rr_ptr, wrapping modulo CORES.
  - A grant happens only when push_ok = !full || (pop && rd_valid).
  - On a grant: FIFO write hold[g], pend[g] cleared (unless re-captured), rr_ptr <= (g+1) mod CORES.
  - No grant when push_ok=0: pend bits hold. This is backpressure; drops occur only when a core fires again while its pend bit is still set.
- FIFO:
  - Storage is DEPTH x 32 with wr_ptr/rd_ptr of AW+1 bits (wrap bit). full when the pointers differ only in the MSB; empty when they are equal.
  - rd_nonce is read combinationally from the head entry.
  - Push and pop in the same cycle: count unchanged. This is legal at full and at DEPTH-1.
  - pop when empty: no effect.
  - Only one entry is written per cycle.
- Latency:
  - found_m[i] high at edge k: pend visible after edge k; FIFO write at edge k+1; rd_valid=1 after edge k+1 (2 cycles).
  - pop at edge k: new head, or rd_valid=0, after edge k.
- new_block=1 (synchronous flush):
  - Clears the pointers, pend, rr_ptr, overflow and drop_cnt at the next edge.
  - found_m and pop in the same cycle are ignored; new_block has priority over every other event.
- Reset asserted mid-operation: outputs take their reset values immediately (asynchronously); all queued nonces are discarded.

Decomposition:
- Shared package miner_pkg:
  - NONCE_W=32, DROP_W=8.
  - typedef nonce_t (logic [NONCE_W-1:0]).
  - Reused by the other miner-side blocks.
- One sub-module, miner_rr_arb:
  - Parameter N.
  - Inputs: req[N], ptr, en. Outputs: gnt one-hot, gnt_idx, vld.
  - Purely combinational; rr_ptr is owned by the parent.

Test Plan:
- Single hit: core1 found_m with nonce 0xDEADBEEF, FIFO empty -> rd_valid=1 two cycles later, rd_nonce=0xDEADBEEF, count=1; pop -> rd_valid=0, rd_nonce=0, count=0.
- Simultaneous hits: found_m=2'b11, nonces 0x11/0x22, rr_ptr=0 -> pop order 0x11 then 0x22; next simultaneous pair 0x33/0x44 -> 0x33 then 0x44 (rr_ptr back at 0 after core1's grant).
- Full/backpressure, DEPTH=16:
  - 16 hits with pop=0 -> count=16.
  - Core0 hit 0xA0 -> pend held, no drop.
  - Core0 hit 0xA1 -> overflow=1, drop_cnt=1.
  - One pop -> 0xA0 enters the FIFO in the same cycle; count stays 16.
- Regrant/re-capture: core0 found on every cycle with the FIFO draining (pop=1) -> no drops, every nonce appears in order, drop_cnt=0.
- Flush: 5 entries queued, overflow=1, new_block coincident with found_m[0] -> next cycle count=0, rd_valid=0, overflow=0, drop_cnt=0; the coincident nonce is absent.
- Reset: rst_main_n low mid-stream with count=7 -> outputs at reset values without waiting for a clock edge; after release, a single hit behaves as in scenario 1.
- Drop saturation: 300 drops -> drop_cnt=255, overflow=1.
